// File: rtl/mul_arbiter_if.sv
// Handshake and result bundle between two requesters and the shared multiplier arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface mul_arbiter_if;
  logic       req0;
  logic [3:0] m0;
  logic [3:0] q0;
  logic       gnt0;
  logic       vld0;
  logic [7:0] p0;
  logic       req1;
  logic [3:0] m1;
  logic [3:0] q1;
  logic       gnt1;
  logic       vld1;
  logic [7:0] p1;
  logic       busy;

  modport slave (
    input  req0, m0, q0, req1, m1, q1,
    output gnt0, vld0, p0, gnt1, vld1, p1, busy
  );

  modport master (
    output req0, m0, q0, req1, m1, q1,
    input  gnt0, vld0, p0, gnt1, vld1, p1, busy
  );
endinterface

// File: rtl/mul_arbiter.sv
// Two requesters time-share one 4x4 shift-add multiplier under round-robin arbitration.
// One product every 6 cycles: grant edge, 4 accumulate edges, then a DONE cycle.
//
// state | meaning
// IDLE  | arbitrate between req0/req1 at every edge
// CALC  | one shift-add step per edge, 4 steps total
// DONE  | result pulse cycle, returns to IDLE unconditionally
module mul_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic [3:0] m_reg_q, m_reg_d;
  logic [3:0] q_reg_q, q_reg_d;
  logic [7:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic       gnt0_q, gnt0_d;
  logic       gnt1_q, gnt1_d;
  logic       vld0_q, vld0_d;
  logic       vld1_q, vld1_d;
  logic [7:0] p0_q, p0_d;
  logic [7:0] p1_q, p1_d;

  logic       any_req;
  logic       pick;
  logic [7:0] partial;
  logic [7:0] acc_sum;

  // last_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      m_reg_q <= 4'h0;
      q_reg_q <= 4'h0;
      acc_q   <= 8'h00;
      cnt_q   <= 2'd0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      p0_q    <= 8'h00;
      p1_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      m_reg_q <= m_reg_d;
      q_reg_q <= q_reg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
    end
  end

  assign any_req = bus.req0 | bus.req1;
  assign pick    = (bus.req0 & bus.req1) ? ~last_q : bus.req1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = CALC;
      CALC:    if (cnt_q == 2'd3) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered pulses; the final CALC edge loads p with the completed sum.
  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    m_reg_d = m_reg_q;
    q_reg_d = q_reg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
    p0_d    = p0_q;
    p1_d    = p1_q;

    partial = q_reg_q[cnt_q] ? (8'(m_reg_q) << cnt_q) : 8'h00;
    acc_sum = acc_q + partial;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d = pick;
          last_d  = pick;
          m_reg_d = pick ? bus.m1 : bus.m0;
          q_reg_d = pick ? bus.q1 : bus.q0;
          acc_d   = 8'h00;
          cnt_d   = 2'd0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          if (owner_q) begin
            p1_d   = acc_sum;
            vld1_d = 1'b1;
          end else begin
            p0_d   = acc_sum;
            vld0_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.gnt0 = gnt0_q;
    bus.gnt1 = gnt1_q;
    bus.vld0 = vld0_q;
    bus.vld1 = vld1_q;
    bus.p0   = p0_q;
    bus.p1   = p1_q;
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: directed scenarios followed by random traffic,
// each cycle compared against a timing/arithmetic model of the arbiter.
module tb_mul_arbiter;

  logic clk;
  logic rst_n;
  mul_arbiter_if bus ();

  mul_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;
  int busy_cnt = 0;

  // Reference model: a job granted at edge g completes at g+4 and frees the arbiter at g+6.
  int         free_at;
  bit         last_who;
  bit         job_act;
  int         g_edge;
  bit         g_who;
  int         g_prod;
  logic [7:0] ep0, ep1;
  logic       exp_gnt0, exp_gnt1, exp_vld0, exp_vld1, exp_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    free_at  = 0;
    last_who = 1'b1;
    job_act  = 1'b0;
    ep0 = 8'h00; ep1 = 8'h00;
    exp_gnt0 = 0; exp_gnt1 = 0; exp_vld0 = 0; exp_vld1 = 0; exp_busy = 0;
  endtask

  task automatic model_edge();
    bit r0, r1, who;
    r0 = bus.req0;
    r1 = bus.req1;
    if (job_act && edge_n == g_edge + 4) begin
      if (g_who) ep1 = g_prod[7:0];
      else       ep0 = g_prod[7:0];
    end
    if (edge_n >= free_at && (r0 || r1)) begin
      who      = (r0 && r1) ? ~last_who : r1;
      job_act  = 1'b1;
      g_edge   = edge_n;
      g_who    = who;
      g_prod   = who ? int'(bus.m1) * int'(bus.q1) : int'(bus.m0) * int'(bus.q0);
      free_at  = edge_n + 6;
      last_who = who;
    end
    exp_gnt0 = job_act && edge_n == g_edge && !g_who;
    exp_gnt1 = job_act && edge_n == g_edge && g_who;
    exp_vld0 = job_act && edge_n == g_edge + 4 && !g_who;
    exp_vld1 = job_act && edge_n == g_edge + 4 && g_who;
    exp_busy = job_act && (edge_n - g_edge) <= 4;
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rst_n) model_edge();
    #1;
    chk("gnt0", bus.gnt0, exp_gnt0);
    chk("gnt1", bus.gnt1, exp_gnt1);
    chk("vld0", bus.vld0, exp_vld0);
    chk("vld1", bus.vld1, exp_vld1);
    chk("busy", bus.busy, exp_busy);
    chk("p0", bus.p0, ep0);
    chk("p1", bus.p1, ep1);
    chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
    chk("vld_excl", bus.vld0 & bus.vld1, 0);
    if (bus.busy === 1'b1) busy_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", bus.busy, 0);
    chk("rst_vld0", bus.vld0, 0);
    chk("rst_vld1", bus.vld1, 0);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_gnt1", bus.gnt1, 0);
    chk("rst_p0", bus.p0, 0);
    chk("rst_p1", bus.p1, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req0 = 0; bus.m0 = 0; bus.q0 = 0;
    bus.req1 = 0; bus.m1 = 0; bus.q1 = 0;
    model_reset();
    #2;
    do_reset();
    tick();

    // Single request 15*15
    bus.req0 = 1; bus.m0 = 4'd15; bus.q0 = 4'd15;
    busy_cnt = 0;
    tick();
    chk("single_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    for (int k = 1; k <= 4; k++) tick();
    chk("single_vld0", bus.vld0, 1);
    chk("single_p0", bus.p0, 225);
    tick(); tick();
    chk("single_busy_cycles", busy_cnt, 5);
    chk("single_p1", bus.p1, 0);

    // Tie after reset: 0 first, then 1, then 0 again
    do_reset();
    bus.req0 = 1; bus.m0 = 4'd3; bus.q0 = 4'd5;
    bus.req1 = 1; bus.m1 = 4'd7; bus.q1 = 4'd9;
    for (int k = 0; k <= 12; k++) begin
      tick();
      if (k == 0)  chk("tie_gnt0_e0", bus.gnt0, 1);
      if (k == 4)  chk("tie_p0_e4", bus.p0, 15);
      if (k == 6)  chk("tie_gnt1_e6", bus.gnt1, 1);
      if (k == 10) chk("tie_p1_e10", bus.p1, 63);
      if (k == 12) chk("tie_gnt0_e12", bus.gnt0, 1);
    end
    bus.req0 = 0; bus.req1 = 0;
    for (int k = 0; k < 6; k++) tick();

    // Zero operands on requester 1
    bus.req1 = 1; bus.m1 = 4'd0; bus.q1 = 4'd9;
    tick();
    bus.req1 = 0;
    for (int k = 1; k <= 4; k++) tick();
    chk("zero_m_vld1", bus.vld1, 1);
    chk("zero_m_p1", bus.p1, 0);
    tick();
    bus.req1 = 1; bus.m1 = 4'd9; bus.q1 = 4'd0;
    tick();
    bus.req1 = 0;
    for (int k = 1; k <= 4; k++) tick();
    chk("zero_q_vld1", bus.vld1, 1);
    chk("zero_q_p1", bus.p1, 0);
    tick();

    // Operand change after grant must not disturb the running product
    bus.req0 = 1; bus.m0 = 4'd6; bus.q0 = 4'd10;
    tick();
    bus.req0 = 0;
    tick();
    bus.m0 = 4'd2;
    for (int k = 2; k <= 4; k++) tick();
    chk("opchg_p0", bus.p0, 60);
    tick();

    // Request during busy waits for the first IDLE edge
    bus.req0 = 1; bus.m0 = 4'd11; bus.q0 = 4'd13;
    tick();
    bus.req0 = 0;
    tick(); tick();
    bus.req1 = 1; bus.m1 = 4'd2; bus.q1 = 4'd3;
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("busy_no_gnt1", bus.gnt1, 0);
    end
    tick();
    chk("busy_gnt1_e6", bus.gnt1, 1);
    bus.req1 = 0;
    for (int k = 0; k < 5; k++) tick();
    chk("busy_p1", bus.p1, 6);
    chk("busy_p0", bus.p0, 143);

    // Reset two edges into CALC aborts the job
    bus.req0 = 1; bus.m0 = 4'd5; bus.q0 = 4'd5;
    tick();
    bus.req0 = 0;
    tick(); tick();
    #2;
    do_reset();
    for (int k = 0; k < 3; k++) tick();
    bus.req0 = 1; bus.m0 = 4'd4; bus.q0 = 4'd3;
    tick();
    bus.req0 = 0;
    for (int k = 1; k <= 4; k++) tick();
    chk("post_rst_p0", bus.p0, 12);
    tick();

    // Random traffic: requesters hold req until granted, operands churn otherwise
    for (int c = 0; c < 800; c++) begin
      if (exp_gnt0) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.m0 = 4'($urandom_range(0, 15)); bus.q0 = 4'($urandom_range(0, 15));
        end else bus.req0 = 0;
      end else if (!bus.req0) begin
        bus.m0 = 4'($urandom_range(0, 15)); bus.q0 = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) bus.req0 = 1;
      end
      if (exp_gnt1) begin
        if ($urandom_range(0, 3) == 0) begin
          bus.m1 = 4'($urandom_range(0, 15)); bus.q1 = 4'($urandom_range(0, 15));
        end else bus.req1 = 0;
      end else if (!bus.req1) begin
        bus.m1 = 4'($urandom_range(0, 15)); bus.q1 = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 4) == 0) bus.req1 = 1;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
